// File: rtl/control_fsm.sv
// Multi-cycle control FSM for a small RISC-V style datapath.
// The state register walks FETCH -> DECODE -> per-class states -> FETCH.
// All strobes are decoded from the state register. The one exception is the
// FETCH IR/PC load, which is qualified by mem_ready so the instruction word
// is latched only on the cycle that memory returns it.
//
// Handshake: mem_ready is a completion flag from memory. A state that issues
// a memory request (FETCH, MEM_RD, MEM_WR) holds its request steady and stays
// put until it sees mem_ready=1 at a rising edge. The request and the
// completion are then retired on that same edge.
module control_fsm (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       ir_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       i_or_d,
   output logic       reg_write,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       alu_op1,
   output logic       alu_op2,
   output logic       illegal_instr,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADDR = 4'd2,
      MEM_RD   = 4'd3,
      MEM_WB   = 4'd4,
      MEM_WR   = 4'd5,
      EXEC     = 4'd6,
      ALU_WB   = 4'd7,
      BRANCH   = 4'd8,
      TRAP     = 4'd9
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   state_t cur_state;
   state_t nxt_state;

   assign state = cur_state;

   // State register. The asynchronous reset forces FETCH immediately, which
   // aborts any in-flight access with no clock edge required.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state <= FETCH;
      end else begin
         cur_state <= nxt_state;
      end
   end

   // Next-state logic. Unused codes 10-15 fall back to FETCH.
   always_comb begin
      nxt_state = FETCH;
      case (cur_state)
         FETCH:    nxt_state = mem_ready ? DECODE : FETCH;
         DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: nxt_state = MEM_ADDR;
               OP_RTYPE:          nxt_state = EXEC;
               OP_BRANCH:         nxt_state = BRANCH;
               default:           nxt_state = TRAP;
            endcase
         end
         MEM_ADDR: nxt_state = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
         MEM_RD:   nxt_state = mem_ready ? MEM_WB : MEM_RD;
         MEM_WB:   nxt_state = FETCH;
         MEM_WR:   nxt_state = mem_ready ? FETCH : MEM_WR;
         EXEC:     nxt_state = ALU_WB;
         ALU_WB:   nxt_state = FETCH;
         BRANCH:   nxt_state = FETCH;
         TRAP:     nxt_state = TRAP;
         default:  nxt_state = FETCH;
      endcase
   end

   // Output decode from the state register. The IR/PC load in FETCH is also
   // gated by rst_n so that nothing is written while reset is held.
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      i_or_d        = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op1       = 1'b0;
      alu_op2       = 1'b0;
      illegal_instr = 1'b0;
      case (cur_state)
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready & rst_n;
            pc_write  = mem_ready & rst_n;
         end
         DECODE: begin
            alu_src_b = 2'b10;
         end
         MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         MEM_RD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         MEM_WR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         EXEC: begin
            alu_src_a = 1'b1;
            alu_op2   = 1'b1;
         end
         ALU_WB: begin
            reg_write = 1'b1;
         end
         BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op1       = 1'b1;
            pc_write_cond = 1'b1;
         end
         TRAP: begin
            illegal_instr = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm. For each instruction, the reference model plans the
// whole expected per-cycle trace ahead of time: the state code and the
// mem_ready value to apply in every cycle. The plan is built from the
// instruction class and the chosen memory wait counts. Expected strobes for
// each cycle come from the per-state output table.
module tb_control_fsm;

   logic       clk;
   logic       rst_n;
   logic [6:0] opcode;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d;
   logic       reg_write, mem_to_reg, alu_src_a, alu_op1, alu_op2, illegal_instr;
   logic [1:0] alu_src_b;
   logic [3:0] state;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       ir_write;
      logic       mem_read;
      logic       mem_write;
      logic       i_or_d;
      logic       reg_write;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       alu_op1;
      logic       alu_op2;
      logic       illegal_instr;
   } outs_t;

   outs_t outs_vec;
   assign outs_vec = '{pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d,
                       reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op1, alu_op2,
                       illegal_instr};

   control_fsm dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .ir_write      (ir_write),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .i_or_d        (i_or_d),
      .reg_write     (reg_write),
      .mem_to_reg    (mem_to_reg),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op1       (alu_op1),
      .alu_op2       (alu_op2),
      .illegal_instr (illegal_instr),
      .state         (state)
   );

   // Clock and reset block.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   // Expected trace: the state code per cycle and the mem_ready to apply.
   logic [3:0] exp_q[$];
   logic       mr_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Per-state strobe table; anything not listed for a state is 0.
   function automatic outs_t exp_outs(input logic [3:0] st, input logic mr);
      outs_t o;
      o = '0;
      case (st)
         4'd0: begin o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr; end
         4'd1: o.alu_src_b = 2'b10;
         4'd2: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
         4'd3: begin o.mem_read = 1'b1; o.i_or_d = 1'b1; end
         4'd4: begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
         4'd5: begin o.mem_write = 1'b1; o.i_or_d = 1'b1; end
         4'd6: begin o.alu_src_a = 1'b1; o.alu_op2 = 1'b1; end
         4'd7: o.reg_write = 1'b1;
         4'd8: begin o.alu_src_a = 1'b1; o.alu_op1 = 1'b1; o.pc_write_cond = 1'b1; end
         4'd9: o.illegal_instr = 1'b1;
         default: ;
      endcase
      return o;
   endfunction

   function automatic logic is_legal(input logic [6:0] op);
      return (op == 7'b0000011) || (op == 7'b0100011) || (op == 7'b0110011) || (op == 7'b1100011);
   endfunction

   task automatic push(input logic [3:0] st, input logic mr);
      exp_q.push_back(st);
      mr_q.push_back(mr);
   endtask

   // Reference model: expected trace of one instruction from its FETCH onward.
   // fw and mw are the numbers of cycles that memory stalls in fetch and in
   // the data access.
   task automatic plan_instr(input logic [6:0] op, input int fw, input int mw);
      exp_q.delete();
      mr_q.delete();
      repeat (fw) push(4'd0, 1'b0);
      push(4'd0, 1'b1);
      push(4'd1, 1'($urandom_range(0, 1)));
      if (op == 7'b0000011) begin
         push(4'd2, 1'($urandom_range(0, 1)));
         repeat (mw) push(4'd3, 1'b0);
         push(4'd3, 1'b1);
         push(4'd4, 1'($urandom_range(0, 1)));
      end else if (op == 7'b0100011) begin
         push(4'd2, 1'($urandom_range(0, 1)));
         repeat (mw) push(4'd5, 1'b0);
         push(4'd5, 1'b1);
      end else if (op == 7'b0110011) begin
         push(4'd6, 1'($urandom_range(0, 1)));
         push(4'd7, 1'($urandom_range(0, 1)));
      end else if (op == 7'b1100011) begin
         push(4'd8, 1'($urandom_range(0, 1)));
      end else begin
         repeat (3 + $urandom_range(0, 3)) push(4'd9, 1'($urandom_range(0, 1)));
      end
   endtask

   // Reset asserted between negedges. Checks hold both before and after a
   // clock edge taken while reset is active. Returns at a negedge with reset
   // released.
   task automatic reset_check(input string tag);
      mem_ready = 1'b1;
      #1;
      check({tag, "_state"}, 32'(state), 32'd0);
      check({tag, "_outs"}, 32'(outs_vec), 32'(exp_outs(4'd0, 1'b0)));
      @(negedge clk);
      check({tag, "_state_edge"}, 32'(state), 32'd0);
      check({tag, "_outs_edge"}, 32'(outs_vec), 32'(exp_outs(4'd0, 1'b0)));
      rst_n = 1'b1;
   endtask

   // Driver: applies the planned trace one cycle at a time and checks the
   // outputs mid-cycle. If abort_idx is reached, reset is pulled low part-way
   // through that cycle.
   task automatic execute(input logic [6:0] op, input int abort_idx);
      opcode = op;
      for (int i = 0; i < exp_q.size(); i++) begin
         mem_ready = mr_q[i];
         #1;
         check("state", 32'(state), 32'(exp_q[i]));
         check("outs", 32'(outs_vec), 32'(exp_outs(exp_q[i], mr_q[i])));
         check("rd_wr_excl", 32'(mem_read & mem_write), 32'd0);
         check("wr_excl", 32'($countones({reg_write, pc_write, mem_write}) > 1), 32'd0);
         if (i == abort_idx) begin
            #2;
            rst_n = 1'b0;
            #1;
            check("abort_mem_write", 32'(mem_write), 32'd0);
            reset_check("abort");
            return;
         end
         @(negedge clk);
      end
      if (exp_q[exp_q.size() - 1] == 4'd9) begin
         rst_n = 1'b0;
         reset_check("trap_reset");
      end
   endtask

   task automatic run(input logic [6:0] op, input int fw, input int mw, input int abort_idx);
      plan_instr(op, fw, mw);
      execute(op, abort_idx);
   endtask

   initial begin
      logic [6:0] op;
      int         sel;
      rst_n     = 1'b0;
      mem_ready = 1'b0;
      opcode    = 7'd0;
      @(negedge clk);
      reset_check("por");

      run(7'b0110011, 0, 0, -1);   // R-type, 4 cycles
      run(7'b0000011, 0, 3, -1);   // load, 3 stall cycles in MEM_RD
      run(7'b1100011, 0, 0, -1);   // branch, 3 cycles
      run(7'b0100011, 0, 3, 3);    // store, reset during MEM_WR
      run(7'b0100011, 0, 0, -1);   // store, 4 cycles
      run(7'b1111111, 0, 0, -1);   // illegal -> trap, then reset
      run(7'b0110011, 5, 0, -1);   // 5-cycle fetch stall

      for (int n = 0; n < 60; n++) begin
         sel = $urandom_range(0, 8);
         case (sel)
            0, 1: op = 7'b0000011;
            2, 3: op = 7'b0100011;
            4, 5: op = 7'b0110011;
            6, 7: op = 7'b1100011;
            default: begin
               op = 7'($urandom_range(0, 127));
               while (is_legal(op)) op = 7'($urandom_range(0, 127));
            end
         endcase
         plan_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
         if (exp_q[exp_q.size() - 1] != 4'd9 && $urandom_range(0, 7) == 0)
            execute(op, $urandom_range(0, exp_q.size() - 1));
         else
            execute(op, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
